// File: rtl/counter_pkg.sv
// Shared definitions for the up/down/load counter and its bench.
package counter_pkg;

  localparam int unsigned CNT_WIDTH_DEFAULT = 4;

  // Operation applied at a clock edge, in priority order.
  typedef enum logic [1:0] {
    OP_LOAD = 2'd0,
    OP_DOWN = 2'd1,
    OP_UP   = 2'd2
  } cnt_op_e;

  // All-ones value of the given width (1..32), zero-extended to 32 bits.
  function automatic logic [31:0] all_ones(input int unsigned width);
    logic [63:0] wide;
    wide = (64'd1 << width) - 64'd1;
    return wide[31:0];
  endfunction

endpackage

// File: rtl/updown_load_counter.sv
// Binary up/down counter with synchronous parallel load and all-ones flag.
module updown_load_counter
  import counter_pkg::*;
#(
  parameter int unsigned WIDTH = CNT_WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             load_en,
  input  logic [WIDTH-1:0] load,
  input  logic             down,
  output logic [WIDTH-1:0] count,
  output logic             rollover
);

  cnt_op_e          op;
  logic [WIDTH-1:0] count_nxt;

  // Select the operation (load beats direction) and form the next count.
  always_comb begin
    op        = OP_UP;
    count_nxt = count + 1'b1;
    if (load_en) begin
      op        = OP_LOAD;
      count_nxt = load;
    end else if (down) begin
      op        = OP_DOWN;
      count_nxt = count - 1'b1;
    end
  end

  // Count register; reset clears it without waiting for a clock edge.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      count <= '0;
    end else begin
      count <= count_nxt;
    end
  end

  assign rollover = &count;

endmodule

// File: tb/tb_updown_load_counter.sv
// Bench for updown_load_counter: reference model, per-cycle compare and
// directed literal checks.
module tb_updown_load_counter;
  import counter_pkg::*;

  localparam int unsigned W = 4;

  logic         clk = 1'b0;
  logic         rstn = 1'b1;
  logic         load_en = 1'b0;
  logic [W-1:0] load = '0;
  logic         down = 1'b0;
  logic [W-1:0] count;
  logic         rollover;

  int compared = 0;
  int mismatched = 0;
  int exp_count = 0;
  bit checking = 1'b1;

  updown_load_counter #(.WIDTH(W)) dut (
    .clk      (clk),
    .rstn     (rstn),
    .load_en  (load_en),
    .load     (load),
    .down     (down),
    .count    (count),
    .rollover (rollover)
  );

  always #5 clk = ~clk;

  // Reference model: what the count must be from the priority rules.
  always @(posedge clk or negedge rstn) begin
    if (!rstn)
      exp_count = 0;
    else if (load_en)
      exp_count = int'(load);
    else if (down)
      exp_count = (exp_count + int'(all_ones(W))) & int'(all_ones(W));
    else
      exp_count = (exp_count + 1) & int'(all_ones(W));
  end

  // Per-cycle compare against the model, away from the active edge.
  always @(negedge clk) begin
    if (checking) begin
      logic [W-1:0] e;
      logic         er;
      e  = exp_count[W-1:0];
      er = (exp_count == int'(all_ones(W)));
      compared++;
      if (count !== e || rollover !== er) begin
        mismatched++;
        $display("FAIL model_cycle t=%0t count=%h rollover=%b expected count=%h rollover=%b",
                 $time, count, rollover, e, er);
      end
    end
  end

  task automatic check(input string name, input logic [W-1:0] ec, input logic er);
    compared++;
    if (count !== ec || rollover !== er) begin
      mismatched++;
      $display("FAIL %s t=%0t count=%h rollover=%b expected count=%h rollover=%b",
               name, $time, count, rollover, ec, er);
    end
  endtask

  task automatic step(input logic le, input logic [W-1:0] lv, input logic dn);
    load_en = le;
    load    = lv;
    down    = dn;
    @(negedge clk);
  endtask

  initial begin
    #1 rstn = 1'b0;

    // Reset held for 5 clocks
    repeat (5) begin
      @(negedge clk);
      check("reset_hold", 4'h0, 1'b0);
    end
    rstn = 1'b1;
    step(1'b0, 4'h0, 1'b0); check("release_1", 4'h1, 1'b0);
    step(1'b0, 4'h0, 1'b0); check("release_2", 4'h2, 1'b0);
    step(1'b0, 4'h0, 1'b0); check("release_3", 4'h3, 1'b0);

    // Up wrap
    step(1'b1, 4'hE, 1'b0); check("upwrap_load", 4'hE, 1'b0);
    step(1'b0, 4'h0, 1'b0); check("upwrap_F", 4'hF, 1'b1);
    step(1'b0, 4'h0, 1'b0); check("upwrap_0", 4'h0, 1'b0);
    step(1'b0, 4'h0, 1'b0); check("upwrap_1", 4'h1, 1'b0);

    // Down wrap (loading the current value keeps it)
    step(1'b1, 4'h1, 1'b0); check("load_same", 4'h1, 1'b0);
    step(1'b0, 4'h0, 1'b1); check("dnwrap_0", 4'h0, 1'b0);
    step(1'b0, 4'h0, 1'b1); check("dnwrap_F", 4'hF, 1'b1);
    step(1'b0, 4'h0, 1'b1); check("dnwrap_E", 4'hE, 1'b0);

    // Load priority over down
    step(1'b1, 4'h5, 1'b0); check("prio_5", 4'h5, 1'b0);
    step(1'b1, 4'hA, 1'b1); check("prio_A", 4'hA, 1'b0);
    repeat (3) begin
      step(1'b1, 4'hA, 1'b1); check("prio_hold", 4'hA, 1'b0);
    end
    step(1'b1, 4'hF, 1'b1); check("load_ones", 4'hF, 1'b1);

    // Asynchronous reset between edges
    step(1'b1, 4'h8, 1'b0); check("async_8", 4'h8, 1'b0);
    step(1'b0, 4'h0, 1'b0); check("async_9", 4'h9, 1'b0);
    #2 rstn = 1'b0;
    #1 check("async_clear", 4'h0, 1'b0);
    @(negedge clk);
    check("async_held", 4'h0, 1'b0);
    rstn = 1'b1;
    @(negedge clk);
    check("async_release", 4'h1, 1'b0);

    // Random inputs at random times, kept off the clock edges
    for (int i = 0; i < 40; i++) begin
      int unsigned d;
      d = $urandom_range(30, 1);
      #(d);
      if ($time % 5 == 0) #1;
      load_en = ($urandom_range(3, 0) == 0);
      load    = W'($urandom_range(15, 0));
      down    = $urandom_range(1, 0) == 1;
    end

    @(negedge clk);
    checking = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
